// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: scheduler state encoding, default timing and counter sizing
package uart_tx_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, GAP, DONE} state_t;
  localparam int GAP_CYC_DEF = 10;
  localparam int TMO_CYC_DEF = 131071;
  localparam int LEN_W = 4;
  function automatic int cnt_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter keeping a last-served pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served1,
  output logic [1:0] gnt
);
  logic last;
  always_ff @(posedge clk)
    if (!rst_n) last <= 1'b1;
    else if (upd) last <= served1;
  assign gnt = &req ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: serializes byte strings from two requesters onto one shared UART byte transmitter
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int GAP_CYC = GAP_CYC_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [LEN_W-1:0] Len0,
  input  logic [LEN_W-1:0] Len1,
  input  logic [7:0]       Byte0,
  input  logic [7:0]       Byte1,
  output logic [LEN_W-1:0] Byte_Idx,
  output logic [1:0]       Grant,
  output logic [7:0]       Tx_Data,
  output logic             Send_En,
  input  logic             Tx_Done,
  output logic [1:0]       Ack,
  output logic [1:0]       Err,
  output logic             Busy
);
  localparam int GW = cnt_w(GAP_CYC);
  localparam int TW = cnt_w(TMO_CYC);
  state_t state, state_d;
  logic [LEN_W-1:0] len;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [1:0] arb_gnt;
  logic [LEN_W-1:0] req_len;
  logic last_byte, tmo_hit;
  assign req_len = arb_gnt[0] ? Len0 : Len1;
  assign last_byte = Byte_Idx == len - LEN_W'(1);
  assign tmo_hit = state == WAIT && !Tx_Done && tmo_cnt == TW'(TMO_CYC - 1);
  assign Send_En = state == START;
  assign Ack = state == DONE ? Grant : 2'b00;
  assign Busy = state != IDLE;
  rr_arb2 u_arb (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .req    ({Req1, Req0}),
    .upd    (state == DONE || tmo_hit),
    .served1(Grant[1]),
    .gnt    (arb_gnt)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (|arb_gnt) state_d = req_len == '0 ? DONE : LOAD;
      LOAD:    state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (Tx_Done) state_d = last_byte ? DONE : (GAP_CYC == 0 ? LOAD : GAP);
               else if (tmo_hit) state_d = IDLE;
      GAP:     if (gap_cnt == GW'(GAP_CYC - 1)) state_d = LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= IDLE;
      Grant    <= '0;
      len      <= '0;
      Byte_Idx <= '0;
      Tx_Data  <= '0;
      gap_cnt  <= '0;
      tmo_cnt  <= '0;
      Err      <= '0;
    end else begin
      state   <= state_d;
      Err     <= tmo_hit ? Grant : 2'b00;
      tmo_cnt <= state == WAIT ? tmo_cnt + TW'(1) : '0;
      gap_cnt <= state == GAP ? gap_cnt + GW'(1) : '0;
      if (state == IDLE && |arb_gnt) begin
        Grant    <= arb_gnt;
        len      <= req_len;
        Byte_Idx <= '0;
      end
      if (state == LOAD) Tx_Data <= Grant[0] ? Byte0 : Byte1;
      if (state == WAIT && Tx_Done && !last_byte) Byte_Idx <= Byte_Idx + LEN_W'(1);
      // leaving a string (completion or abort) releases the transmitter
      if (state != IDLE && state_d == IDLE) begin
        Grant    <= '0;
        Byte_Idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized scoreboard bench for the two-requester UART string scheduler
module tb_uart_tx_sched;
  localparam int GAP = 10;
  localparam int TMO = 200;
  logic Clk = 0, Rst_n = 0, Req0 = 0, Req1 = 0, Tx_Done = 0;
  logic [3:0] Len0 = 0, Len1 = 0, Byte_Idx;
  logic [7:0] Byte0, Byte1, Tx_Data;
  logic [1:0] Grant, Ack, Err;
  logic Send_En, Busy;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  typedef struct {int kind; int who; int data; int idx;} ev_t;
  typedef struct {int lat; bit spur;} rsp_t;
  ev_t sb[$];
  rsp_t rq[$];
  int n_chk = 0, n_pass = 0, cyc = 0, send_cyc = 0, done_cyc = 0, last_srv = 1;

  always #10 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  assign Byte0 = mem0[Byte_Idx];
  assign Byte1 = mem1[Byte_Idx];

  uart_tx_sched #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req0(Req0), .Req1(Req1), .Len0(Len0), .Len1(Len1),
    .Byte0(Byte0), .Byte1(Byte1), .Byte_Idx(Byte_Idx), .Grant(Grant), .Tx_Data(Tx_Data),
    .Send_En(Send_En), .Tx_Done(Tx_Done), .Ack(Ack), .Err(Err), .Busy(Busy)
  );

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // monitor: every DUT event consumes the next expected event
  always @(negedge Clk) begin : mon
    ev_t e;
    if (Rst_n && Send_En) begin
      if (sb.size() == 0) chk(0, "unexpected_send", Tx_Data, -1);
      else begin
        e = sb.pop_front();
        chk(e.kind == 0, "send_kind", 0, e.kind);
        chk(Tx_Data == e.data, "tx_data", Tx_Data, e.data);
        chk(Grant == e.who && $onehot(Grant), "send_grant", Grant, e.who);
        chk(Byte_Idx == e.idx, "byte_idx", Byte_Idx, e.idx);
        if (e.idx != 0) chk(cyc - done_cyc == GAP + 2, "gap_len", cyc - done_cyc, GAP + 2);
      end
      send_cyc = cyc;
    end
    if (Rst_n && |Ack) begin
      if (sb.size() == 0) chk(0, "unexpected_ack", Ack, 0);
      else begin
        e = sb.pop_front();
        chk(e.kind == 1, "ack_kind", 1, e.kind);
        chk(Ack == e.who, "ack_bit", Ack, e.who);
      end
    end
    if (Rst_n && |Err) begin
      if (sb.size() == 0) chk(0, "unexpected_err", Err, 0);
      else begin
        e = sb.pop_front();
        chk(e.kind == 2, "err_kind", 2, e.kind);
        chk(Err == e.who, "err_bit", Err, e.who);
        chk(cyc - send_cyc == TMO + 1, "tmo_len", cyc - send_cyc, TMO + 1);
        chk(Grant == 0 && !Busy, "err_idle", {Busy, Grant}, 0);
      end
    end
  end

  // byte transmitter model: answers each Send_En after its planned latency (0 = never)
  initial begin : resp
    rsp_t r;
    @(negedge Clk);
    forever begin
      if (Rst_n && Send_En && rq.size() > 0) begin
        r = rq.pop_front();
        if (r.lat > 0) begin
          repeat (r.lat) @(negedge Clk);
          Tx_Done = 1;
          done_cyc = cyc;
          @(negedge Clk);
          Tx_Done = 0;
          if (r.spur) begin
            repeat (2) @(negedge Clk);
            Tx_Done = 1;
            @(negedge Clk);
            Tx_Done = 0;
          end
        end else @(negedge Clk);
      end else @(negedge Clk);
    end
  end

  task automatic plan(input int s, input int len, input bit w, input int lat, input bit spur);
    for (int i = 0; i < len; i++) begin
      sb.push_back('{0, 1 << s, s == 0 ? int'(mem0[i]) : int'(mem1[i]), i});
      rq.push_back('{w ? 0 : lat, spur});
      if (w) begin
        sb.push_back('{2, 1 << s, 0, 0});
        last_srv = s;
        return;
      end
    end
    sb.push_back('{1, 1 << s, 0, 0});
    last_srv = s;
  endtask

  task automatic waiter(input int side, input int max_ack);
    int t0;
    bit scr;
    t0 = cyc;
    scr = 0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge Clk);
      if (Grant[side] && !scr) begin
        scr = 1;
        if (side == 0) Len0 = 4'($urandom);
        else Len1 = 4'($urandom);
      end
      if (Ack[side] || Err[side]) begin
        if (max_ack > 0) chk(cyc - t0 <= max_ack, "ack_latency", cyc - t0, max_ack);
        if (side == 0) Req0 = 0;
        else Req1 = 0;
        return;
      end
    end
    chk(0, "waiter_timeout", side, 0);
    if (side == 0) Req0 = 0;
    else Req1 = 0;
  endtask

  task automatic round(input bit a0, input bit a1, input int l0, input int l1, input bit w0,
                       input bit w1, input int lat, input bit spur, input int max_ack);
    int first;
    first = (a0 && a1) ? (last_srv == 1 ? 0 : 1) : (a0 ? 0 : 1);
    for (int n = 0; n < 2; n++) begin
      int s;
      s = n == 0 ? first : 1 - first;
      if (s == 0 ? a0 : a1) plan(s, s == 0 ? l0 : l1, s == 0 ? w0 : w1, lat, spur);
    end
    @(negedge Clk);
    Len0 = 4'(l0);
    Len1 = 4'(l1);
    Req0 = a0;
    Req1 = a1;
    fork
      if (a0) waiter(0, max_ack);
      if (a1) waiter(1, max_ack);
    join
    repeat (3) @(negedge Clk);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 8'($urandom);
      mem1[i] = 8'($urandom);
    end
  endtask

  initial begin
    randomize_mem();
    repeat (3) @(negedge Clk);
    chk(Grant == 0, "rst_grant", Grant, 0);
    chk(!Busy && !Send_En, "rst_busy_send", {Busy, Send_En}, 0);
    chk(Byte_Idx == 0 && Tx_Data == 0, "rst_idx_data", {Byte_Idx, Tx_Data}, 0);
    chk(Ack == 0 && Err == 0, "rst_ack_err", {Ack, Err}, 0);
    Rst_n = 1;
    round(1, 1, 2, 2, 0, 0, 7, 0, 0);
    mem0[0] = 8'h48; mem0[1] = 8'h45; mem0[2] = 8'h4C; mem0[3] = 8'h4C; mem0[4] = 8'h4F;
    round(1, 0, 5, 0, 0, 0, 100, 0, 0);
    round(0, 1, 0, 0, 0, 0, 5, 0, 3);
    randomize_mem();
    round(1, 0, 3, 0, 1, 0, 5, 0, 0);
    round(1, 0, 4, 0, 0, 0, 6, 1, 0);
    randomize_mem();
    sb.push_back('{0, 1, int'(mem0[0]), 0});
    rq.push_back('{5, 0});
    sb.push_back('{0, 1, int'(mem0[1]), 1});
    rq.push_back('{0, 0});
    @(negedge Clk);
    Len0 = 4;
    Req0 = 1;
    for (int k = 0; k < 200 && sb.size() > 0; k++) @(negedge Clk);
    chk(sb.size() == 0, "rst_pre_bytes", sb.size(), 0);
    repeat (4) @(negedge Clk);
    Rst_n = 0;
    @(negedge Clk);
    chk(Grant == 0 && !Busy, "mid_rst_grant_busy", {Busy, Grant}, 0);
    chk(Byte_Idx == 0 && Tx_Data == 0, "mid_rst_idx_data", {Byte_Idx, Tx_Data}, 0);
    chk(Ack == 0 && Err == 0 && !Send_En, "mid_rst_pulses", {Ack, Err, Send_En}, 0);
    Req0 = 0;
    sb.delete();
    rq.delete();
    last_srv = 1;
    @(negedge Clk);
    Rst_n = 1;
    round(1, 0, 2, 0, 0, 0, 4, 0, 0);
    for (int t = 0; t < 25; t++) begin
      int m;
      randomize_mem();
      m = $urandom_range(1, 3);
      round(m[0], m[1], $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(1, 30), $urandom_range(0, 1) == 1, 0);
    end
    chk(sb.size() == 0, "sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter GAP_CYC, default 10, idle clock cycles inserted between consecutive bytes of one string (0 = no gap).
REQ-002 Parameter TMO_CYC, default 131071, maximum cycles to wait for Tx_Done per byte before abort.
REQ-003 Clk  input  1  system clock, 50 MHz (20 ns period).
REQ-004 Rst_n  input  1  reset, synchronous, active-low.
REQ-005 Req0 / Req1  input  1 each  string transmit request, level, held by requester until Ack/Err.
REQ-006 Len0 / Len1  input  4 each  string length in bytes, 0..15.
REQ-007 Byte0 / Byte1  input  8 each  requester byte at index Byte_Idx, combinational from requester.
REQ-008 Byte_Idx  output  4  index of byte currently requested from granted requester.
REQ-009 Grant  output  2  one-hot owner of shared byte transmitter, 2'b00 when idle.
REQ-010 Tx_Data  output  8  byte to shared UART byte transmitter.
REQ-011 Send_En  output  1  one-cycle start pulse to byte transmitter.
REQ-012 Tx_Done  input  1  one-cycle pulse from byte transmitter, byte finished.
REQ-013 Ack  output  2  one-cycle pulse on bit of requester whose string completed.
REQ-014 Err  output  2  one-cycle pulse on bit of requester whose string aborted on timeout.
REQ-015 Busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States SHALL be IDLE, LOAD, START, WAIT, GAP, DONE.
REQ-017 IDLE: if any Req high, SHALL grant by round-robin, i.e. the requester not served last wins on contention; Grant, latched length and Byte_Idx=0 valid next cycle; next state LOAD.
REQ-018 Len latched at grant; Len/Req changes during a string SHALL be ignored until DONE.
REQ-019 Latched length 0: SHALL go directly to DONE, Ack pulse, Send_En never asserted.
REQ-020 LOAD (1 cycle): Tx_Data registered from selected Byte input; next START.
REQ-021 START (1 cycle): Send_En=1; timeout counter cleared; next WAIT.
REQ-022 WAIT: on Tx_Done, if Byte_Idx == length-1 go DONE; else Byte_Idx increments and go GAP (or LOAD if GAP_CYC=0).
REQ-023 GAP: count GAP_CYC cycles then LOAD.
REQ-024 WAIT timeout counter reaching TMO_CYC with no Tx_Done: Err pulse for granted bit, Grant cleared, go IDLE.
REQ-025 DONE (1 cycle): Ack pulse for granted bit; Grant cleared, Byte_Idx=0, last-served pointer updated; next IDLE.
REQ-026 Tx_Done outside WAIT SHALL be ignored.
REQ-027 Timeout abort SHALL also update last-served pointer.
REQ-028 Req still high in cycle after Ack/Err SHALL be eligible again; other requester wins if also requesting.
REQ-029 Grant SHALL be one-hot or zero at all times; Tx_Data stable from LOAD until next LOAD.

Reset
REQ-030 Rst_n low at a Clk edge: state IDLE, Grant 0, Byte_Idx 0, Tx_Data 0, Send_En 0, Ack 0, Err 0, Busy 0, counters 0, last-served = Req1 (Req0 wins first contention).
REQ-031 Reset mid-string SHALL abandon it without Ack or Err.

Structure
REQ-032 Package uart_tx_sched_pkg holds state encoding, GAP_CYC/TMO_CYC defaults and counter widths.
REQ-033 Sub-module rr_arb2 (two-input round-robin arbiter with last-served pointer) instantiated once.

Verification
REQ-034 Req0=1, Len0=5, bytes "HELLO", Tx_Done 100 cycles after each Send_En -> 5 Send_En pulses, Tx_Data 0x48,0x45,0x4C,0x4C,0x4F, gaps of 10 cycles, single Ack=2'b01.
REQ-035 Req0 and Req1 rise same cycle, Len 2 each -> Grant 2'b01 first, then 2'b10; Ack 01 then 10; no overlap.
REQ-036 Len1=0, Req1=1 -> Ack=2'b10 within 3 cycles, no Send_En.
REQ-037 Req0=1, Len0=3, Tx_Done withheld, TMO_CYC=200 -> Err=2'b01 after 200 WAIT cycles, Grant 0, Busy 0.
REQ-038 Rst_n low during second byte of 4-byte string -> all outputs reset values next edge, no Ack/Err; new Req0 after release restarts at Byte_Idx 0.
REQ-039 Tx_Done pulsed during GAP -> ignored; byte count and Ack timing unchanged.
